// File: rtl/csr_exec_if.sv
// Issue bundle from the CSR issue queue and the CDB broadcast port of the CSR execution unit.
interface csr_exec_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 6
);
   // Issue side (*_awake bundle)
   logic              ready_awake;
   logic [TAG_W-1:0]  tag_rob_awake;
   logic [3:0]        Conf_awake;
   logic [TAG_W-1:0]  Pj_awake;
   logic [TAG_W-1:0]  Pd_old_awake;
   logic [TAG_W-1:0]  Pd_awake;
   logic [13:0]       csr_addr_awake;
   logic              RegWr_awake;
   logic              csrWr_awake;
   // CDB side
   logic              cdb_ready;
   logic              cdb_RegWr;
   logic [TAG_W-1:0]  cdb_Pd;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;

   // Issue queue / CDB listener side
   modport master (
      output ready_awake, tag_rob_awake, Conf_awake, Pj_awake, Pd_old_awake, Pd_awake,
             csr_addr_awake, RegWr_awake, csrWr_awake,
      input  cdb_ready, cdb_RegWr, cdb_Pd, cdb_tag, cdb_data
   );

   // Execution unit side
   modport slave (
      input  ready_awake, tag_rob_awake, Conf_awake, Pj_awake, Pd_old_awake, Pd_awake,
             csr_addr_awake, RegWr_awake, csrWr_awake,
      output cdb_ready, cdb_RegWr, cdb_Pd, cdb_tag, cdb_data
   );
endinterface

// File: rtl/csr_exec_unit.sv
// CSR execution unit: one-stage operand read/compute (S1), registered CDB broadcast, and a
// commit-gated CSR write path that holds a write until the ROB commits the owning op.
module csr_exec_unit #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned TAG_W      = 6,
   parameter logic [3:0]  CONF_CSRRD = 4'd1,
   parameter logic [3:0]  CONF_CSRWR = 4'd2,
   parameter logic [3:0]  CONF_CSRXG = 4'd3,
   parameter logic [3:0]  CONF_CPU   = 4'd4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   csr_exec_if.slave         iss,
   output logic [TAG_W-1:0]  prf_raddr_j,
   output logic [TAG_W-1:0]  prf_raddr_k,
   input  logic [DATA_W-1:0] prf_rdata_j,
   input  logic [DATA_W-1:0] prf_rdata_k,
   output logic [13:0]       csr_raddr,
   input  logic [DATA_W-1:0] csr_rdata,
   output logic [4:0]        cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   output logic              csr_we,
   output logic [13:0]       csr_waddr,
   output logic [DATA_W-1:0] csr_wdata,
   input  logic              commit_csr,
   input  logic [TAG_W-1:0]  commit_tag,
   output logic              csr_done,
   output logic              err_proto
);

   typedef enum logic [1:0] {StIdle, StWaitCmt, StWrite} state_e;

   state_e            state_q, state_d;
   logic              wr_latch;

   logic              s1_valid_q;
   logic [TAG_W-1:0]  s1_tag_q, s1_pj_q, s1_pd_old_q, s1_pd_q;
   logic [3:0]        s1_conf_q;
   logic [13:0]       s1_csr_addr_q;
   logic              s1_regwr_q, s1_csrwr_q;

   logic [13:0]       wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [TAG_W-1:0]  wr_tag_q;

   logic              issue_ok;
   logic [DATA_W-1:0] s1_result, s1_new_val;

   // Issue is only taken while no write is in flight; flush wins over a same-cycle issue.
   assign issue_ok = iss.ready_awake && !flush && (state_q == StIdle);

   // S1 operand addresses come straight from the latched bundle.
   assign prf_raddr_j = s1_pj_q;
   assign prf_raddr_k = s1_pd_old_q;
   assign csr_raddr   = s1_csr_addr_q;
   assign cfg_addr    = prf_rdata_j[4:0];

   // S1 result and new CSR value (CSRXG merges rd_old under the rj mask).
   always_comb begin
      s1_result  = (s1_conf_q == CONF_CPU) ? cfg_data : csr_rdata;
      s1_new_val = (s1_conf_q == CONF_CSRWR) ? prf_rdata_k
                 : ((csr_rdata & ~prf_rdata_j) | (prf_rdata_k & prf_rdata_j));
   end

   // S1 stage register: latch an accepted issue, empty otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q    <= 1'b0;
         s1_tag_q      <= '0;
         s1_conf_q     <= '0;
         s1_pj_q       <= '0;
         s1_pd_old_q   <= '0;
         s1_pd_q       <= '0;
         s1_csr_addr_q <= '0;
         s1_regwr_q    <= 1'b0;
         s1_csrwr_q    <= 1'b0;
      end else begin
         s1_valid_q <= issue_ok;
         if (issue_ok) begin
            s1_tag_q      <= iss.tag_rob_awake;
            s1_conf_q     <= iss.Conf_awake;
            s1_pj_q       <= iss.Pj_awake;
            s1_pd_old_q   <= iss.Pd_old_awake;
            s1_pd_q       <= iss.Pd_awake;
            s1_csr_addr_q <= iss.csr_addr_awake;
            s1_regwr_q    <= iss.RegWr_awake;
            s1_csrwr_q    <= iss.csrWr_awake;
         end
      end
   end

   // CDB output register: one-cycle broadcast per S1 op, cleared by flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         iss.cdb_ready <= 1'b0;
         iss.cdb_RegWr <= 1'b0;
         iss.cdb_Pd    <= '0;
         iss.cdb_tag   <= '0;
         iss.cdb_data  <= '0;
      end else if (flush) begin
         iss.cdb_ready <= 1'b0;
         iss.cdb_RegWr <= 1'b0;
         iss.cdb_Pd    <= '0;
         iss.cdb_tag   <= '0;
         iss.cdb_data  <= '0;
      end else begin
         iss.cdb_ready <= s1_valid_q;
         if (s1_valid_q) begin
            iss.cdb_RegWr <= s1_regwr_q;
            iss.cdb_Pd    <= s1_pd_q;
            iss.cdb_tag   <= s1_tag_q;
            iss.cdb_data  <= s1_result;
         end
      end
   end

   // Write FSM next state; a matching commit beats a same-cycle flush in WAIT_CMT.
   always_comb begin
      state_d  = state_q;
      wr_latch = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (s1_valid_q && s1_csrwr_q && !flush) begin
               state_d  = StWaitCmt;
               wr_latch = 1'b1;
            end
         end
         StWaitCmt: begin
            if (commit_csr && (commit_tag == wr_tag_q)) state_d = StWrite;
            else if (flush)                              state_d = StIdle;
         end
         StWrite: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM state and pending-write holding registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_tag_q  <= '0;
      end else begin
         state_q <= state_d;
         if (wr_latch) begin
            wr_addr_q <= s1_csr_addr_q;
            wr_data_q <= s1_new_val;
            wr_tag_q  <= s1_tag_q;
         end
      end
   end

   // Sticky protocol error: issue arrived while a write was outstanding.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                            err_proto <= 1'b0;
      else if (iss.ready_awake && (state_q != StIdle))     err_proto <= 1'b1;
   end

   assign csr_we    = (state_q == StWrite);
   assign csr_done  = (state_q == StWrite);
   assign csr_waddr = wr_addr_q;
   assign csr_wdata = wr_data_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Scoreboard bench for csr_exec_unit: expected CDB and CSR-write events are queued when stimulus
// is issued and checked by an independent negedge monitor.
module tb_csr_exec_unit;
   localparam logic [3:0] RD = 4'd1, WR = 4'd2, XG = 4'd3, CPU = 4'd4;

   typedef struct {logic [5:0] tag; logic [5:0] pd; logic [31:0] data; logic regwr;} cdb_t;
   typedef struct {logic [13:0] addr; logic [31:0] data;} wr_t;

   logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
   logic [5:0]  prf_raddr_j, prf_raddr_k, commit_tag;
   logic [31:0] prf_rdata_j, prf_rdata_k, csr_rdata, cfg_data, csr_wdata;
   logic [13:0] csr_raddr, csr_waddr;
   logic [4:0]  cfg_addr;
   logic        csr_we, csr_done, err_proto, commit_csr;

   logic [31:0] prf_mem [0:63];
   logic [31:0] csr_mem [0:16383];

   cdb_t exp_cdb[$];
   wr_t  exp_wr[$];
   int   n_checks = 0, n_fail = 0;

   csr_exec_if #(.DATA_W(32), .TAG_W(6)) bus ();

   csr_exec_unit dut (
      .clk(clk), .rst(rst), .flush(flush), .iss(bus.slave),
      .prf_raddr_j(prf_raddr_j), .prf_raddr_k(prf_raddr_k),
      .prf_rdata_j(prf_rdata_j), .prf_rdata_k(prf_rdata_k),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
      .commit_csr(commit_csr), .commit_tag(commit_tag),
      .csr_done(csr_done), .err_proto(err_proto)
   );

   always #5 clk = ~clk;

   assign prf_rdata_j = prf_mem[prf_raddr_j];
   assign prf_rdata_k = prf_mem[prf_raddr_k];
   assign csr_rdata   = csr_mem[csr_raddr];
   assign cfg_data    = 32'hC0F0_0000 | {27'd0, cfg_addr};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [3:0] conf, input logic [5:0] tag, input logic [5:0] pj,
                        input logic [5:0] pd_old, input logic [5:0] pd, input logic [13:0] addr,
                        input logic regwr, input logic csrwr);
      bus.ready_awake    = 1'b1;
      bus.Conf_awake     = conf;
      bus.tag_rob_awake  = tag;
      bus.Pj_awake       = pj;
      bus.Pd_old_awake   = pd_old;
      bus.Pd_awake       = pd;
      bus.csr_addr_awake = addr;
      bus.RegWr_awake    = regwr;
      bus.csrWr_awake    = csrwr;
      @(posedge clk); #1;
      bus.ready_awake    = 1'b0;
   endtask

   task automatic commit(input logic [5:0] tag, input logic with_flush);
      commit_csr = 1'b1;
      commit_tag = tag;
      flush      = with_flush;
      @(posedge clk); #1;
      commit_csr = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every CDB broadcast and every CSR write must match the head of its queue.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.cdb_ready) begin
            if (exp_cdb.size() == 0) check("cdb_unexpected", 32'd1, 32'd0);
            else begin
               cdb_t e;
               e = exp_cdb.pop_front();
               check("cdb_tag", {26'd0, bus.cdb_tag}, {26'd0, e.tag});
               check("cdb_pd", {26'd0, bus.cdb_Pd}, {26'd0, e.pd});
               check("cdb_data", bus.cdb_data, e.data);
               check("cdb_regwr", {31'd0, bus.cdb_RegWr}, {31'd0, e.regwr});
            end
         end
         if (csr_we) begin
            if (exp_wr.size() == 0) check("csr_we_unexpected", 32'd1, 32'd0);
            else begin
               wr_t w;
               w = exp_wr.pop_front();
               check("csr_waddr", {18'd0, csr_waddr}, {18'd0, w.addr});
               check("csr_wdata", csr_wdata, w.data);
               check("csr_done_with_we", {31'd0, csr_done}, 32'd1);
            end
         end else if (csr_done) begin
            check("csr_done_unexpected", 32'd1, 32'd0);
         end
      end
   end

   initial begin
      for (int i = 0; i < 64; i++) prf_mem[i] = 32'd0;
      for (int i = 0; i < 16384; i++) csr_mem[i] = 32'd0;
      prf_mem[10] = 32'h0000_1234;
      prf_mem[11] = 32'h0000_FF00;
      prf_mem[12] = 32'hAAAA_AAAA;
      prf_mem[13] = 32'd5;
      csr_mem[14'h0]  = 32'hB0;
      csr_mem[14'h1]  = 32'h11;
      csr_mem[14'h2]  = 32'h22;
      csr_mem[14'h3]  = 32'h33;
      csr_mem[14'h6]  = 32'h55;
      csr_mem[14'h7]  = 32'h77;
      csr_mem[14'h9]  = 32'h99;
      csr_mem[14'h20] = 32'h1234_5678;
      bus.ready_awake = 1'b0; bus.Conf_awake = '0; bus.tag_rob_awake = '0; bus.Pj_awake = '0;
      bus.Pd_old_awake = '0; bus.Pd_awake = '0; bus.csr_addr_awake = '0;
      bus.RegWr_awake = 1'b0; bus.csrWr_awake = 1'b0;
      commit_csr = 1'b0; commit_tag = '0;

      idle(3);
      rst = 1'b1;
      idle(1);
      check("rst_cdb_ready", {31'd0, bus.cdb_ready}, 32'd0);
      check("rst_cdb_data", bus.cdb_data, 32'd0);
      check("rst_csr_we", {31'd0, csr_we}, 32'd0);
      check("rst_csr_done", {31'd0, csr_done}, 32'd0);
      check("rst_err_proto", {31'd0, err_proto}, 32'd0);

      // 1: CSRRD csr 0x0
      exp_cdb.push_back('{tag: 6'd3, pd: 6'd7, data: 32'hB0, regwr: 1'b1});
      issue(RD, 6'd3, 6'd0, 6'd0, 6'd7, 14'h0, 1'b1, 1'b0);
      idle(4);

      // 2: CSRWR csr 0x6, write only after commit of tag 9
      exp_cdb.push_back('{tag: 6'd9, pd: 6'd8, data: 32'h55, regwr: 1'b1});
      issue(WR, 6'd9, 6'd0, 6'd10, 6'd8, 14'h6, 1'b1, 1'b1);
      idle(5);
      exp_wr.push_back('{addr: 14'h6, data: 32'h0000_1234});
      commit(6'd9, 1'b0);
      idle(3);

      // 3: CSRXG merge under mask
      exp_cdb.push_back('{tag: 6'd5, pd: 6'd9, data: 32'h1234_5678, regwr: 1'b1});
      issue(XG, 6'd5, 6'd11, 6'd12, 6'd9, 14'h20, 1'b1, 1'b1);
      idle(3);
      exp_wr.push_back('{addr: 14'h20, data: 32'h1234_AA78});
      commit(6'd5, 1'b0);
      idle(3);

      // 4: back-to-back reads, then a CPU_CONF read of word 5
      exp_cdb.push_back('{tag: 6'd20, pd: 6'd1, data: 32'h11, regwr: 1'b1});
      exp_cdb.push_back('{tag: 6'd21, pd: 6'd2, data: 32'h22, regwr: 1'b0});
      exp_cdb.push_back('{tag: 6'd22, pd: 6'd3, data: 32'h33, regwr: 1'b1});
      exp_cdb.push_back('{tag: 6'd23, pd: 6'd4, data: 32'hC0F0_0005, regwr: 1'b1});
      issue(RD, 6'd20, 6'd0, 6'd0, 6'd1, 14'h1, 1'b1, 1'b0);
      issue(RD, 6'd21, 6'd0, 6'd0, 6'd2, 14'h2, 1'b0, 1'b0);
      issue(RD, 6'd22, 6'd0, 6'd0, 6'd3, 14'h3, 1'b1, 1'b0);
      issue(CPU, 6'd23, 6'd13, 6'd0, 6'd4, 14'h0, 1'b1, 1'b0);
      idle(4);

      // 5: wrong-tag commit ignored, flush discards the pending write
      exp_cdb.push_back('{tag: 6'd8, pd: 6'd5, data: 32'h77, regwr: 1'b1});
      issue(WR, 6'd8, 6'd0, 6'd10, 6'd5, 14'h7, 1'b1, 1'b1);
      idle(3);
      commit(6'd4, 1'b0);
      idle(2);
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      idle(2);
      commit(6'd8, 1'b0);
      idle(2);
      exp_cdb.push_back('{tag: 6'd2, pd: 6'd6, data: 32'hB0, regwr: 1'b1});
      issue(RD, 6'd2, 6'd0, 6'd0, 6'd6, 14'h0, 1'b1, 1'b0);
      idle(4);
      check("err_proto_clear", {31'd0, err_proto}, 32'd0);

      // 6: issue while pending is dropped and flagged; commit beats a same-cycle flush
      exp_cdb.push_back('{tag: 6'd12, pd: 6'd10, data: 32'h55, regwr: 1'b1});
      issue(WR, 6'd12, 6'd0, 6'd12, 6'd10, 14'h6, 1'b1, 1'b1);
      idle(2);
      issue(RD, 6'd13, 6'd0, 6'd0, 6'd11, 14'h1, 1'b1, 1'b0);
      idle(1);
      check("err_proto_set", {31'd0, err_proto}, 32'd1);
      exp_wr.push_back('{addr: 14'h6, data: 32'hAAAA_AAAA});
      commit(6'd12, 1'b1);
      idle(3);

      // Async reset mid-WAIT_CMT loses the pending write
      exp_cdb.push_back('{tag: 6'd30, pd: 6'd12, data: 32'h99, regwr: 1'b1});
      issue(WR, 6'd30, 6'd0, 6'd10, 6'd12, 14'h9, 1'b1, 1'b1);
      idle(3);
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      idle(1);
      check("rst2_err_proto", {31'd0, err_proto}, 32'd0);
      commit(6'd30, 1'b0);
      idle(4);

      for (int i = 0; i < 50 && (exp_cdb.size() != 0 || exp_wr.size() != 0); i++) idle(1);
      check("cdb_queue_drained", exp_cdb.size(), 32'd0);
      check("wr_queue_drained", exp_wr.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
